rr_completion_ctrl: RTL

//  Completion-side partner of the register-rename (RR) unit: consumes its allocation outputs and drives its

---
 rtl/rr_completion_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rr_completion_ctrl.sv
// rr_completion_ctrl: in-order writeback and single-target recovery driver for the register-rename unit.
// Optional protocol checking is enabled by defining RRC_PROTO_CHECK_EN.
module rr_completion_ctrl #(
  parameter int INSTR_COUNT = 2,
  parameter int C_NUM = 4,
  parameter int K = 8,
  localparam int DEPTH = (C_NUM-1)*K,
  localparam int ROB_W = $clog2(DEPTH),
  localparam int RHT_W = $clog2(C_NUM*K),
  localparam int OCC_W = $clog2(DEPTH+1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                alloc_en_i,
  input  logic [INSTR_COUNT-1:0][ROB_W-1:0]   alloc_rob_id_i,
  input  logic [INSTR_COUNT-1:0][RHT_W-1:0]   alloc_rht_id_i,
  input  logic                                wb_go_i,
  input  logic                                rec_req_i,
  input  logic [ROB_W-1:0]                    rec_age_i,
  input  logic                                rec_busy_i,
  output logic [INSTR_COUNT-1:0]              wb_en_o,
  output logic [INSTR_COUNT-1:0][ROB_W-1:0]   rec_rob_id_o,
  output logic [RHT_W-1:0]                    rec_rht_id_o,
  output logic                                rec_en_o,
  output logic                                full_o,
  output logic [OCC_W-1:0]                    occupancy_o,
  output logic                                err_o
);
  typedef enum logic [1:0] {RUN, REC_ISSUE, REC_WAIT} state_t;
  state_t state_q, state_d;
  logic [ROB_W-1:0] fifo_rob_q [DEPTH];
  logic [RHT_W-1:0] fifo_rht_q [DEPTH];
  logic [ROB_W-1:0] head_q, head_d, tail_q, tail_d, rec_idx;
  logic [OCC_W-1:0] occ_q, occ_d, n_wb;
  logic [INSTR_COUNT-1:0] wb_en_q, wb_en_d;
  logic [INSTR_COUNT-1:0][ROB_W-1:0] rec_rob_id_q, rec_rob_id_d;
  logic [RHT_W-1:0] rec_rht_id_q, rec_rht_id_d;
  logic rec_en_q, rec_en_d, full_q, full_d, err_q, err_d;
  logic rec_ok, ovf, ids_bad, push, do_wb;
  // Pointer sums stay below 2*DEPTH, so one conditional subtract wraps them.
  function automatic logic [ROB_W-1:0] wrap(input logic [ROB_W:0] x);
    return (x >= (ROB_W+1)'(DEPTH)) ? ROB_W'(x - (ROB_W+1)'(DEPTH)) : ROB_W'(x);
  endfunction
  always_comb begin
    ids_bad = 1'b0;
`ifdef RRC_PROTO_CHECK_EN
    for (int i = 0; i < INSTR_COUNT; i++)
      ids_bad = ids_bad | (int'(alloc_rob_id_i[i]) >= DEPTH) | (int'(alloc_rht_id_i[i]) >= C_NUM*K);
`endif
  end
  assign rec_ok  = rec_req_i && (int'(rec_age_i) < int'(occ_q));
  assign ovf     = int'(occ_q) + INSTR_COUNT > DEPTH;
  assign do_wb   = wb_go_i && !rec_req_i && !rec_busy_i;
  assign rec_idx = wrap({1'b0, head_q} + {1'b0, rec_age_i});
  assign push    = state_q == RUN && !rec_ok && alloc_en_i && !ovf && !ids_bad;
  assign n_wb    = (state_q != RUN || rec_ok || !do_wb) ? '0 :
                   (occ_q < OCC_W'(INSTR_COUNT)) ? occ_q : OCC_W'(INSTR_COUNT);
  always_comb begin
    state_d      = state_q;
    head_d       = wrap({1'b0, head_q} + (ROB_W+1)'(n_wb));
    tail_d       = push ? wrap({1'b0, tail_q} + (ROB_W+1)'(INSTR_COUNT)) : tail_q;
    occ_d        = occ_q + (push ? OCC_W'(INSTR_COUNT) : '0) - n_wb;
    wb_en_d      = '0;
    rec_en_d     = 1'b0;
    rec_rob_id_d = rec_rob_id_q;
    rec_rht_id_d = rec_rht_id_q;
    for (int i = 0; i < INSTR_COUNT; i++)
      if (OCC_W'(i) < n_wb) begin
        wb_en_d[i]      = 1'b1;
        rec_rob_id_d[i] = fifo_rob_q[wrap({1'b0, head_q} + (ROB_W+1)'(i))];
      end
    if (state_q == RUN && rec_ok) begin
      state_d         = REC_ISSUE;
      rec_en_d        = 1'b1;
      rec_rob_id_d[0] = fifo_rob_q[rec_idx];
      rec_rht_id_d    = fifo_rht_q[rec_idx];
      tail_d          = wrap({1'b0, rec_idx} + 1'b1);
      occ_d           = OCC_W'(rec_age_i) + 1'b1;
    end else if (state_q == REC_ISSUE) begin
      state_d = REC_WAIT;
    end else if (state_q == REC_WAIT && !rec_busy_i) begin
      state_d = RUN;
    end
    full_d = int'(occ_d) > DEPTH - INSTR_COUNT;
`ifdef RRC_PROTO_CHECK_EN
    err_d = err_q | (state_q == RUN && ((alloc_en_i && !rec_ok && (ovf || ids_bad)) || (rec_req_i && !rec_ok)));
`else
    err_d = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      wb_en_q      <= '0;
      rec_en_q     <= 1'b0;
      rec_rob_id_q <= '0;
      rec_rht_id_q <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      wb_en_q      <= wb_en_d;
      rec_en_q     <= rec_en_d;
      rec_rob_id_q <= rec_rob_id_d;
      rec_rht_id_q <= rec_rht_id_d;
      full_q       <= full_d;
      err_q        <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push)
      for (int i = 0; i < INSTR_COUNT; i++) begin
        fifo_rob_q[wrap({1'b0, tail_q} + (ROB_W+1)'(i))] <= alloc_rob_id_i[i];
        fifo_rht_q[wrap({1'b0, tail_q} + (ROB_W+1)'(i))] <= alloc_rht_id_i[i];
      end
  end
  assign wb_en_o      = wb_en_q;
  assign rec_en_o     = rec_en_q;
  assign rec_rob_id_o = rec_rob_id_q;
  assign rec_rht_id_o = rec_rht_id_q;
  assign full_o       = full_q;
  assign occupancy_o  = occ_q;
  assign err_o        = err_q;
endmodule
